// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared definitions for the SoC bus arbiter slice.
// Master IDs, arbiter FSM encoding and the read-return tag carried in the
// latency pipe.
package soc_bus_pkg;

  localparam logic MID_M0 = 1'b0;  // instruction bus
  localparam logic MID_M1 = 1'b1;  // data bus

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // One entry per accepted transfer: valid marks a read, id names its issuer.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/avalon_rd_tag_pipe.sv
// avalon_rd_tag_pipe: DEPTH-stage shift register of read-return tags.
// The tag leaving the last stage lines up with the slave's read data.
module avalon_rd_tag_pipe
  import soc_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    i_Clk,
  input  logic    i_Rst_n,
  input  rd_tag_t i_Tag,
  output rd_tag_t o_Tag
);

  rd_tag_t r_Pipe [DEPTH];

  // Advance every stage once per cycle; each accepted transfer enters stage 0.
  // NOTE: this small array is reset, unlike a data RAM: a stale valid bit here
  // would present a phantom read return after reset.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_Pipe[i] <= '0;
    end else begin
      r_Pipe[0] <= i_Tag;
      for (int i = 1; i < DEPTH; i++) r_Pipe[i] <= r_Pipe[i-1];
    end
  end

  assign o_Tag = r_Pipe[DEPTH-1];

endmodule

// File: rtl/avalon_slave_arbiter.sv
// avalon_slave_arbiter: two-master (M0 instruction, M1 data) to one-slave
// Avalon-MM arbiter with zero-cycle grant, grant lock through slave
// waitrequest, and tagged read-data return.
// Build option: define ARB_FIXED_PRIO_EN to make M1 always win conflicts
// (no round-robin history); otherwise arbitration is round-robin.
module avalon_slave_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  // M0: instruction bus, read only
  input  logic [ADDR_W-1:0] i_M0_Addr,
  input  logic              i_M0_Read,
  output logic              o_M0_WaitRequest,
  output logic [DATA_W-1:0] o_M0_ReadData,
  output logic              o_M0_ReadDataValid,
  // M1: data bus
  input  logic [ADDR_W-1:0] i_M1_Addr,
  input  logic              i_M1_Read,
  input  logic              i_M1_Write,
  input  logic [DATA_W-1:0] i_M1_WriteData,
  input  logic [3:0]        i_M1_ByteEnable,
  output logic              o_M1_WaitRequest,
  output logic [DATA_W-1:0] o_M1_ReadData,
  output logic              o_M1_ReadDataValid,
  // shared slave
  output logic [ADDR_W-1:0] o_S_Addr,
  output logic              o_S_Read,
  output logic              o_S_Write,
  output logic [DATA_W-1:0] o_S_WriteData,
  output logic [3:0]        o_S_ByteEnable,
  input  logic [DATA_W-1:0] i_S_ReadData,
  input  logic              i_S_WaitRequest
);

  arb_state_e r_State;
  logic       r_LockId;
`ifndef ARB_FIXED_PRIO_EN
  logic       r_LastGrant;
`endif

  logic    w_Req0;
  logic    w_Req1;
  logic    w_Winner;
  logic    w_Grant;
  logic    w_GrantValid;
  logic    w_Active;
  logic    w_Accept;
  rd_tag_t w_PushTag;
  rd_tag_t w_TailTag;

  assign w_Req0 = i_M0_Read;
  assign w_Req1 = i_M1_Read | i_M1_Write;

  // Fresh arbitration among the current requests (used in IDLE only).
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_Winner = MID_M0;
    if (w_Req0 && w_Req1) begin
`ifdef ARB_FIXED_PRIO_EN
      w_Winner = MID_M1;
`else
      w_Winner = (r_LastGrant == MID_M1) ? MID_M0 : MID_M1;
`endif
    end else if (w_Req1) begin
      w_Winner = MID_M1;
    end
  end

  // Current grantee: the locked master while stalled in HOLD, else the winner.
  always_comb begin
    w_Grant      = w_Winner;
    w_GrantValid = w_Req0 | w_Req1;
    if (r_State == HOLD) begin
      w_Grant      = r_LockId;
      w_GrantValid = 1'b1;
    end
  end

  // Reset gates the slave strobes directly so they drop with rst_n, not a clock later.
  assign w_Active = w_GrantValid & i_Rst_n;
  assign w_Accept = w_Active & ~i_S_WaitRequest;

  // Route the grantee's command to the slave. M0 only reads whole words.
  always_comb begin
    o_S_Addr       = i_M0_Addr;
    o_S_Read       = 1'b0;
    o_S_Write      = 1'b0;
    o_S_WriteData  = i_M1_WriteData;
    o_S_ByteEnable = 4'hF;
    if (w_Grant == MID_M1) begin
      o_S_Addr       = i_M1_Addr;
      o_S_ByteEnable = i_M1_ByteEnable;
    end
    if (w_Active) begin
      if (w_Grant == MID_M0) begin
        o_S_Read = 1'b1;
      end else begin
        // Write wins if M1 illegally raises both strobes.
        o_S_Write = i_M1_Write;
        o_S_Read  = i_M1_Read & ~i_M1_Write;
      end
    end
  end

  // A master proceeds only in the cycle its own transfer is accepted.
  assign o_M0_WaitRequest = ~(w_Accept && (w_Grant == MID_M0));
  assign o_M1_WaitRequest = ~(w_Accept && (w_Grant == MID_M1));

  // Arbiter FSM: lock the grantee across slave stalls, track round-robin history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State     <= IDLE;
      r_LockId    <= MID_M0;
`ifndef ARB_FIXED_PRIO_EN
      r_LastGrant <= MID_M1;
`endif
    end else begin
      case (r_State)
        IDLE: begin
          if (w_GrantValid) begin
            if (i_S_WaitRequest) begin
              r_LockId <= w_Grant;
              r_State  <= HOLD;
            end
`ifndef ARB_FIXED_PRIO_EN
            else begin
              r_LastGrant <= w_Grant;
            end
`endif
          end
        end
        HOLD: begin
          if (!i_S_WaitRequest) begin
`ifndef ARB_FIXED_PRIO_EN
            r_LastGrant <= r_LockId;
`endif
            r_State <= IDLE;
          end
        end
      endcase
    end
  end

  // Every accepted transfer enters the pipe; only reads carry a valid tag.
  assign w_PushTag.valid = w_Accept & o_S_Read;
  assign w_PushTag.id    = w_Grant;

  avalon_rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Tag   (w_PushTag),
    .o_Tag   (w_TailTag)
  );

  assign o_M0_ReadDataValid = w_TailTag.valid && (w_TailTag.id == MID_M0);
  assign o_M1_ReadDataValid = w_TailTag.valid && (w_TailTag.id == MID_M1);
  assign o_M0_ReadData      = i_S_ReadData;
  assign o_M1_ReadData      = i_S_ReadData;

  // A locked master must hold its request until the slave accepts it.
  a_hold_request : assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    (r_State == HOLD) |-> ((r_LockId == MID_M0) ? w_Req0 : w_Req1));

endmodule

// File: tb/tb_avalon_slave_arbiter.sv
// tb_avalon_slave_arbiter: scoreboard bench for avalon_slave_arbiter.
// Two DUTs share all master/slave stimulus: g_dut[0] has READ_LATENCY=1,
// g_dut[1] has READ_LATENCY=3. Stimulus pushes expected slave transfers and
// read returns (with the cycle they are due); a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_avalon_slave_arbiter;

  typedef struct {
    int          due;
    logic [29:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } xfer_t;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } ret_t;

`ifdef ARB_FIXED_PRIO_EN
  localparam logic FIRST_WIN = 1'b1;
`else
  localparam logic FIRST_WIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [29:0] m0_addr, m1_addr;
  logic        m0_read, m1_read, m1_write, s_wait;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;

  logic [1:0]       m0_wait, m1_wait, m0_rv, m1_rv, s_read, s_write;
  logic [1:0][31:0] m0_rd, m1_rd, s_wdata, s_rdata;
  logic [1:0][29:0] s_addr;
  logic [1:0][3:0]  s_be;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    avalon_slave_arbiter #(
      .ADDR_W       (30),
      .DATA_W       (32),
      .READ_LATENCY ((k == 0) ? 1 : 3)
    ) dut (
      .i_Clk              (clk),
      .i_Rst_n            (rst_n),
      .i_M0_Addr          (m0_addr),
      .i_M0_Read          (m0_read),
      .o_M0_WaitRequest   (m0_wait[k]),
      .o_M0_ReadData      (m0_rd[k]),
      .o_M0_ReadDataValid (m0_rv[k]),
      .i_M1_Addr          (m1_addr),
      .i_M1_Read          (m1_read),
      .i_M1_Write         (m1_write),
      .i_M1_WriteData     (m1_wdata),
      .i_M1_ByteEnable    (m1_be),
      .o_M1_WaitRequest   (m1_wait[k]),
      .o_M1_ReadData      (m1_rd[k]),
      .o_M1_ReadDataValid (m1_rv[k]),
      .o_S_Addr           (s_addr[k]),
      .o_S_Read           (s_read[k]),
      .o_S_Write          (s_write[k]),
      .o_S_WriteData      (s_wdata[k]),
      .o_S_ByteEnable     (s_be[k]),
      .i_S_ReadData       (s_rdata[k]),
      .i_S_WaitRequest    (s_wait)
    );
  end

  // ROM contents seen by the slave model: rom(2) = 0x0000a183.
  function automatic logic [31:0] rom(input logic [29:0] a);
    return ({2'b00, a} << 20) ^ 32'h0020a183;
  endfunction

  // Slave model: fixed-latency read data (1 and 3 cycles) from the address bus.
  logic [31:0] sl_pipe [2][3];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sl_pipe[k][0] <= rom(s_addr[k]);
      sl_pipe[k][1] <= sl_pipe[k][0];
      sl_pipe[k][2] <= sl_pipe[k][1];
    end
  end
  assign s_rdata[0] = sl_pipe[0][0];
  assign s_rdata[1] = sl_pipe[1][2];

  int    n_tests = 0;
  int    n_fail  = 0;
  xfer_t sq [2][$];
  ret_t  rq [2][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_xfer(input logic [29:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] be);
    xfer_t e;
    e.due = cyc; e.addr = a; e.wr = wr; e.wdata = wd; e.be = be;
    for (int k = 0; k < 2; k++) sq[k].push_back(e);
  endtask

  task automatic exp_rd(input logic id, input logic [29:0] a);
    ret_t r;
    exp_xfer(a, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      r.due = cyc + ((k == 0) ? 1 : 3); r.id = id; r.data = rom(a);
      rq[k].push_back(r);
    end
  endtask

  // Reset discards everything not yet returned.
  task automatic reset_flush();
    for (int k = 0; k < 2; k++) begin
      while (rq[k].size() > 0 && rq[k][$].due >= cyc) void'(rq[k].pop_back());
      while (sq[k].size() > 0 && sq[k][$].due >= cyc) void'(sq[k].pop_back());
    end
  endtask

  // Monitor: compare slave-side transfers and read returns against the scoreboard.
  always @(negedge clk) begin
    xfer_t e;
    ret_t  r;
    logic  acc;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        acc = (s_read[k] | s_write[k]) & ~s_wait;
        if (sq[k].size() > 0 && sq[k][0].due == cyc) begin
          e = sq[k].pop_front();
          check($sformatf("dut%0d_accept", k), acc, 1'b1);
          check($sformatf("dut%0d_s_addr", k), s_addr[k], e.addr);
          check($sformatf("dut%0d_s_write", k), s_write[k], e.wr);
          check($sformatf("dut%0d_s_read", k), s_read[k], !e.wr);
          if (e.wr) begin
            check($sformatf("dut%0d_s_wdata", k), s_wdata[k], e.wdata);
            check($sformatf("dut%0d_s_be", k), s_be[k], e.be);
          end
        end else if (acc) begin
          check($sformatf("dut%0d_unexpected_accept", k), acc, 1'b0);
        end

        if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
          r = rq[k].pop_front();
          check($sformatf("dut%0d_rv_owner", k), r.id ? m1_rv[k] : m0_rv[k], 1'b1);
          check($sformatf("dut%0d_rv_other", k), r.id ? m0_rv[k] : m1_rv[k], 1'b0);
          check($sformatf("dut%0d_rdata", k), r.id ? m1_rd[k] : m0_rd[k], r.data);
        end else begin
          if (m0_rv[k]) check($sformatf("dut%0d_unexpected_m0_rv", k), m0_rv[k], 1'b0);
          if (m1_rv[k]) check($sformatf("dut%0d_unexpected_m1_rv", k), m1_rv[k], 1'b0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0; s_wait = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] c_m1req;
    logic [3:0] c_win;
    int         n0;
    int         n1;

    m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    idle_inputs();
    // Requests raised during reset must not reach the slave.
    m0_read = 1'b1; m1_write = 1'b1;
    step(); step(); settle();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_dut%0d_m0_wait", k), m0_wait[k], 1'b1);
      check($sformatf("rst_dut%0d_m1_wait", k), m1_wait[k], 1'b1);
      check($sformatf("rst_dut%0d_s_read", k), s_read[k], 1'b0);
      check($sformatf("rst_dut%0d_s_write", k), s_write[k], 1'b0);
      check($sformatf("rst_dut%0d_m0_rv", k), m0_rv[k], 1'b0);
      check($sformatf("rst_dut%0d_m1_rv", k), m1_rv[k], 1'b0);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();

    // Conflict from reset: round-robin M0,M1,M0,M1 (fixed: M1 x3, then M0 alone).
`ifdef ARB_FIXED_PRIO_EN
    c_m1req = 4'b0111; c_win = 4'b0111;
`else
    c_m1req = 4'b1111; c_win = 4'b1010;
`endif
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      m0_read = 1'b1; m0_addr = 30'h10 + 30'(n0);
      m1_read = c_m1req[i]; m1_addr = 30'h20 + 30'(n1);
      exp_rd(c_win[i], c_win[i] ? m1_addr : m0_addr);
      settle();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("conf%0d_dut%0d_m0_wait", i, k), m0_wait[k], c_win[i]);
        check($sformatf("conf%0d_dut%0d_m1_wait", i, k), m1_wait[k], !c_win[i]);
      end
      if (c_win[i]) n1++; else n0++;
      step();
    end
    idle_inputs();
    step();

    // Single M0 read, no conflict.
    m0_read = 1'b1; m0_addr = 30'h2;
    exp_rd(1'b0, 30'h2);
    settle();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t1_dut%0d_s_read", k), s_read[k], 1'b1);
      check($sformatf("t1_dut%0d_m0_wait", k), m0_wait[k], 1'b0);
      check($sformatf("t1_dut%0d_m1_wait", k), m1_wait[k], 1'b1);
    end
    step();
    idle_inputs();
    settle();
    check("t1_dut0_rv_next_cycle", m0_rv[0], 1'b1);
    check("t1_dut0_rdata_a183", m0_rd[0], 32'h0000a183);
    step(); step(); step();

    // M1 write locked through three stall cycles while M0 waits.
    m1_write = 1'b1; m1_addr = 30'h40; m1_wdata = 32'hDEADBEEF; m1_be = 4'hF;
    m0_read = 1'b1; m0_addr = 30'h50; s_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        s_wait = 1'b0;
        exp_xfer(30'h40, 1'b1, 32'hDEADBEEF, 4'hF);
      end
      settle();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("hold%0d_dut%0d_s_write", i, k), s_write[k], 1'b1);
        check($sformatf("hold%0d_dut%0d_s_addr", i, k), s_addr[k], 30'h40);
        check($sformatf("hold%0d_dut%0d_m0_wait", i, k), m0_wait[k], 1'b1);
        check($sformatf("hold%0d_dut%0d_m1_wait", i, k), m1_wait[k], i != 3);
      end
      step();
    end
    m1_write = 1'b0;
    exp_rd(1'b0, 30'h50);
    settle();
    for (int k = 0; k < 2; k++)
      check($sformatf("after_hold_dut%0d_m0_wait", k), m0_wait[k], 1'b0);
    step();
    idle_inputs();
    step(); step(); step();

    // Five back-to-back M0 reads: contiguous returns in both latencies.
    for (int i = 0; i < 5; i++) begin
      m0_read = 1'b1; m0_addr = 30'h60 + 30'(i);
      exp_rd(1'b0, m0_addr);
      step();
    end
    idle_inputs();
    repeat (5) step();

    // Reset with two reads in flight.
    m0_read = 1'b1; m0_addr = 30'h70;
    exp_rd(1'b0, 30'h70);
    step();
    m0_addr = 30'h71;
    exp_rd(1'b0, 30'h71);
    step();
    m0_addr = 30'h72;
    settle();
    rst_n = 1'b0;
    reset_flush();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_dut%0d_s_read", k), s_read[k], 1'b0);
      check($sformatf("midrst_dut%0d_m0_wait", k), m0_wait[k], 1'b1);
    end
    m1_read = 1'b1; m1_addr = 30'h90; m0_addr = 30'h80;
    for (int i = 0; i < 2; i++) begin
      step(); settle();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("inrst%0d_dut%0d_m0_rv", i, k), m0_rv[k], 1'b0);
        check($sformatf("inrst%0d_dut%0d_m1_rv", i, k), m1_rv[k], 1'b0);
      end
    end
    step();
    rst_n = 1'b1;
    exp_rd(FIRST_WIN, FIRST_WIN ? 30'h90 : 30'h80);
    settle();
    for (int k = 0; k < 2; k++)
      check($sformatf("postrst_dut%0d_m0_wait", k), m0_wait[k], FIRST_WIN);
    step();
    m0_read = FIRST_WIN; m1_read = !FIRST_WIN;
    exp_rd(!FIRST_WIN, FIRST_WIN ? 30'h80 : 30'h90);
    step();
    idle_inputs();
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
